mem_responder: RTL and testbench
================================

# mem_responder

Memory-side responder for the CPU's rd/wr strobe interface. It answers the fetch, load and store accesses issued by the CPU control state machine. Each strobe rising edge is accepted as one request with a programmable number of wait states. Reads return a registered byte and writes update a RAM region. ROM-region protection, range checking and sticky error reporting are included. It sits between the CPU address/data buses and the system storage array.

## Interface
Parameters:
- ADDR_W, 13, address width.
- DATA_W, 8, data width.
- DEPTH, 8192, implemented words; must be ≤ 2^ADDR_W.
- RAM_BASE, 13'h1800, first writable address; addresses below it are ROM.
- WAIT_STATES, 1, extra cycles per access; range 0–15.

Ports:
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  reset; one clock, reset asynchronous active-low
- rd  in  1  read strobe from CPU
- wr  in  1  write strobe from CPU
- addr  in  ADDR_W  access address
- data_in  in  DATA_W  store data, valid while wr high
- data_out  out  DATA_W  registered read data
- data_oe  out  1  responder drives the data bus
- ready  out  1  one-cycle access-complete pulse
- busy  out  1  request in progress
- err_clr  in  1  clears err/err_code
- err  out  1  sticky error flag
- err_code  out  3  first error cause since clear

## Operation
- Edge detection: rd_q/wr_q registers; a request is a sampled 0→1 of rd or wr. Held strobes do not retrigger.
- FSM mem_state_t:
  - IDLE→WAIT on accept if WAIT_STATES>0, else IDLE→ACCESS.
  - WAIT counts WAIT_STATES cycles, then →ACCESS.
  - ACCESS→IDLE always.
- addr, data_in and direction are captured at accept; strobes/addr may change afterwards.
- ACCESS read: data_out ← array[addr]. ACCESS write: array[addr] ← data_in.
- ready=1 for the single cycle after the ACCESS edge.
- busy=1 in WAIT and ACCESS.
- data_oe=1 in the ready cycle of a read, then held while rd stays high; cleared on rd low or any new accept.
- data_out holds its value until the next completed read.
- Error codes: 1 write to ROM region, 2 rd and wr edges in the same cycle, 3 edge while busy, 4 addr ≥ DEPTH, 5 parity.
- Error handling:
  - ROM write: full handshake, array untouched, code 1.
  - Out-of-range: read returns 0, write ignored, handshake completes, code 4.
  - Simultaneous rd/wr edges: no access, no ready, code 2.
  - Edge while busy: dropped, code 3.
- err is sticky. err_code latches the first error; simultaneous errors latch the lowest code.
- err_clr clears err and err_code. Any error set in the same cycle as err_clr wins.

## Timing
- Latency: accept edge k → ready visible after edge k+WAIT_STATES+1.
- Back-to-back accept earliest at edge k+WAIT_STATES+2.
- Reset: data_out=0, data_oe=0, ready=0, busy=0, err=0, err_code=0, FSM=IDLE, rd_q=wr_q=0.
- Reset mid-access aborts the access: no array write, no ready. Array contents are not reset.
- After reset release, a strobe already high is not a request; it must fall and rise again.
- Wait counter wraps to 0 on WAIT→ACCESS.

## Configuration
- MEM_RESP_PARITY_EN defined: array stores an even-parity bit per word, computed at write and checked at read. On mismatch, data_out is still updated, err is set with code 5, and ready still pulses.
- MEM_RESP_PARITY_EN undefined: array width DATA_W, no check, code 5 never produced.

## Structure
- mem_resp_pkg holds mem_state_t {IDLE, WAIT, ACCESS} and the err_code_t constants ERR_NONE..ERR_PARITY (0–5).
- Sub-module mem_resp_array holds synchronous-write/synchronous-read storage of DEPTH words, plus the parity bit under the macro.
- Top level holds edge detect, FSM, wait counter, address checks and error logic.

## Test plan
- WAIT_STATES=1: write 8'hA5 @13'h1800, then read @13'h1800 → ready 2 cycles after each accept, data_out=8'hA5, data_oe high until rd falls.
- rd held high 2 cycles (fetch pattern) at 13'h0010 → exactly one ready, no error.
- wr @13'h0100 (ROM) with data 8'h3C → ready pulses, subsequent read unchanged, err=1, err_code=1. Then err_clr → err=0.
- rd edge 1 cycle after accept (busy) → dropped, err_code=3. The original access completes normally.
- rd and wr rise together → no ready, err_code=2. rst_n low during WAIT → outputs reset, no write, no ready.
- MEM_RESP_PARITY_EN: force-flip the stored bit at 13'h1801, then read → err_code=5, ready pulses.

Source files
------------

// File: rtl/mem_resp_pkg.sv
// Shared types for the mem_responder slice: FSM states and error-cause codes.
package mem_resp_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      ACCESS
   } mem_state_t;

   typedef enum logic [2:0] {
      ERR_NONE   = 3'd0,
      ERR_ROM    = 3'd1,
      ERR_BOTH   = 3'd2,
      ERR_BUSY   = 3'd3,
      ERR_RANGE  = 3'd4,
      ERR_PARITY = 3'd5
   } err_code_t;

endpackage

// File: rtl/mem_resp_array.sv
// Storage for mem_responder: synchronous write, registered read of DEPTH words.
// MEM_RESP_PARITY_EN adds an even-parity bit per word, checked on every read.
module mem_resp_array #(
   parameter int unsigned ADDR_W = 13,
   parameter int unsigned DATA_W = 8,
   parameter int unsigned DEPTH  = 8192
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic              re,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata,
   output logic              perr
);

`ifdef MEM_RESP_PARITY_EN
   localparam int unsigned WORD_W = DATA_W + 1;
`else
   localparam int unsigned WORD_W = DATA_W;
`endif

   logic [WORD_W-1:0] mem [DEPTH];
   logic [WORD_W-1:0] wword;
   logic              in_range;

   assign in_range = 32'(addr) < DEPTH;

`ifdef MEM_RESP_PARITY_EN
   assign wword = {^wdata, wdata};
`else
   assign wword = wdata;
`endif

   // Contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (we && in_range) mem[addr] <= wword;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata <= '0;
         perr  <= 1'b0;
      end else begin
         perr <= 1'b0;
         if (re) begin
            if (in_range) begin
               rdata <= mem[addr][DATA_W-1:0];
`ifdef MEM_RESP_PARITY_EN
               perr  <= ^mem[addr];
`endif
            end else begin
               rdata <= '0;
            end
         end
      end
   end

endmodule

// File: rtl/mem_responder.sv
// CPU-side responder: strobe edge detect, wait-state FSM, ROM/range checks, sticky errors.
// Optional MEM_RESP_PARITY_EN enables per-word parity in mem_resp_array (error code 5).
module mem_responder
   import mem_resp_pkg::*;
#(
   parameter int unsigned       ADDR_W      = 13,
   parameter int unsigned       DATA_W      = 8,
   parameter int unsigned       DEPTH       = 8192,
   parameter logic [ADDR_W-1:0] RAM_BASE    = 13'h1800,
   parameter int unsigned       WAIT_STATES = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              rd,
   input  logic              wr,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] data_in,
   output logic [DATA_W-1:0] data_out,
   output logic              data_oe,
   output logic              ready,
   output logic              busy,
   input  logic              err_clr,
   output logic              err,
   output logic [2:0]        err_code
);

   mem_state_t        state, state_nxt;
   logic [3:0]        wcnt, wcnt_nxt;
   logic              rd_q, wr_q, edge_en;
   logic              rd_rise, wr_rise, accept;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic              is_wr_q;
   logic              do_access, in_range, in_rom;
   logic              arr_we, arr_re, perr;
   err_code_t         err_new, err_code_q;

   // edge_en masks the first cycle after reset so a strobe already high is not a request
   assign rd_rise   = edge_en & rd & ~rd_q;
   assign wr_rise   = edge_en & wr & ~wr_q;
   assign accept    = (state == IDLE) & (rd_rise ^ wr_rise);
   assign do_access = (state == ACCESS);
   assign in_range  = 32'(addr_q) < DEPTH;
   assign in_rom    = addr_q < RAM_BASE;
   assign arr_we    = do_access & is_wr_q & in_range & ~in_rom;
   assign arr_re    = do_access & ~is_wr_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         wcnt  <= '0;
      end else begin
         state <= state_nxt;
         wcnt  <= wcnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      wcnt_nxt  = wcnt;
      busy      = 1'b0;
      unique case (state)
         IDLE: begin
            if (accept) state_nxt = (WAIT_STATES > 0) ? WAIT : ACCESS;
         end
         WAIT: begin
            busy = 1'b1;
            if (wcnt == 4'(WAIT_STATES - 1)) begin
               state_nxt = ACCESS;
               wcnt_nxt  = '0;
            end else begin
               wcnt_nxt = wcnt + 4'd1;
            end
         end
         ACCESS: begin
            busy      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         edge_en <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         is_wr_q <= 1'b0;
         ready   <= 1'b0;
         data_oe <= 1'b0;
      end else begin
         rd_q    <= rd;
         wr_q    <= wr;
         edge_en <= 1'b1;
         ready   <= do_access;
         if (accept) begin
            addr_q  <= addr;
            wdata_q <= data_in;
            is_wr_q <= wr_rise;
         end
         if (arr_re)                data_oe <= 1'b1;
         else if (accept || !rd)    data_oe <= 1'b0;
      end
   end

   // Priority order yields the lowest code when several causes coincide
   always_comb begin
      err_new = ERR_NONE;
      if (do_access & is_wr_q & in_rom)       err_new = ERR_ROM;
      else if (rd_rise & wr_rise)             err_new = ERR_BOTH;
      else if (busy & (rd_rise | wr_rise))    err_new = ERR_BUSY;
      else if (do_access & ~in_range)         err_new = ERR_RANGE;
      else if (perr)                          err_new = ERR_PARITY;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err        <= 1'b0;
         err_code_q <= ERR_NONE;
      end else if (err_new != ERR_NONE) begin
         err <= 1'b1;
         if (!err || err_clr) err_code_q <= err_new;
      end else if (err_clr) begin
         err        <= 1'b0;
         err_code_q <= ERR_NONE;
      end
   end

   assign err_code = err_code_q;

   mem_resp_array #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_array (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (arr_we),
      .re    (arr_re),
      .addr  (addr_q),
      .wdata (wdata_q),
      .rdata (data_out),
      .perr  (perr)
   );

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: vector table plus hand-written corner sequences.
module tb_mem_responder;

`ifdef MEM_RESP_PARITY_EN
   localparam int WORD_W = 9;
`else
   localparam int WORD_W = 8;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        rd = 1'b0, wr = 1'b0, err_clr = 1'b0;
   logic [12:0] addr = '0;
   logic [7:0]  data_in = '0;
   logic [7:0]  data_out;
   logic        data_oe, ready, busy, err;
   logic [2:0]  err_code;

   int n_chk = 0;
   int n_pass = 0;

   typedef struct {
      bit         is_rd;
      logic [7:0] data;
   } sb_t;
   sb_t sb[$];

   typedef struct {
      bit          w;
      logic [12:0] a;
      logic [7:0]  d;
      logic [7:0]  exp_rd;
      logic [2:0]  exp_code;
   } vec_t;

   mem_responder #(
      .ADDR_W      (13),
      .DATA_W      (8),
      .DEPTH       (7168),
      .RAM_BASE    (13'h1800),
      .WAIT_STATES (1)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .rd       (rd),
      .wr       (wr),
      .addr     (addr),
      .data_in  (data_in),
      .data_out (data_out),
      .data_oe  (data_oe),
      .ready    (ready),
      .busy     (busy),
      .err_clr  (err_clr),
      .err      (err),
      .err_code (err_code)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
   endtask

   // Scoreboard consumer: every ready pulse must match the oldest expected access.
   always @(negedge clk) begin
      if (rst_n && ready) begin
         if (sb.size() == 0) begin
            chk("unexpected_ready", 32'(ready), 32'd0);
         end else begin
            sb_t e;
            e = sb.pop_front();
            if (e.is_rd) begin
               chk("rd_data", 32'(data_out), 32'(e.data));
               chk("rd_oe", 32'(data_oe), 32'd1);
            end else begin
               chk("wr_oe", 32'(data_oe), 32'd0);
            end
         end
      end
   end

   task automatic wait_ready(output int lat);
      lat = 0;
      for (int n = 1; n <= 10; n++) begin
         @(negedge clk);
         if (ready) begin
            lat = n;
            break;
         end
      end
   endtask

   task automatic do_read(input logic [12:0] a, input logic [7:0] exp);
      int lat;
      @(negedge clk);
      addr = a; rd = 1'b1;
      sb.push_back('{1'b1, exp});
      wait_ready(lat);
      chk("rd_latency", 32'(lat), 32'd3);
      rd = 1'b0;
   endtask

   task automatic do_write(input logic [12:0] a, input logic [7:0] d);
      int lat;
      @(negedge clk);
      addr = a; data_in = d; wr = 1'b1;
      sb.push_back('{1'b0, 8'h00});
      wait_ready(lat);
      chk("wr_latency", 32'(lat), 32'd3);
      wr = 1'b0;
   endtask

   task automatic clear_err();
      @(negedge clk); err_clr = 1'b1;
      @(negedge clk); err_clr = 1'b0;
      chk("err_after_clr", 32'(err), 32'd0);
      chk("code_after_clr", 32'(err_code), 32'd0);
   endtask

   task automatic preload(input logic [12:0] a, input logic [7:0] v);
      dut.u_array.mem[a] = WORD_W'(v);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vec_t vt[13];
      int   lat, cnt;

      vt[0]  = '{1'b1, 13'h1800, 8'hA5, 8'h00, 3'd0};
      vt[1]  = '{1'b0, 13'h1800, 8'h00, 8'hA5, 3'd0};
      vt[2]  = '{1'b1, 13'h1BFF, 8'h5A, 8'h00, 3'd0};
      vt[3]  = '{1'b0, 13'h1BFF, 8'h00, 8'h5A, 3'd0};
      vt[4]  = '{1'b1, 13'h17FF, 8'h77, 8'h00, 3'd1};
      vt[5]  = '{1'b1, 13'h0100, 8'h3C, 8'h00, 3'd1};
      vt[6]  = '{1'b0, 13'h0100, 8'h00, 8'hC3, 3'd0};
      vt[7]  = '{1'b0, 13'h0010, 8'h00, 8'h96, 3'd0};
      vt[8]  = '{1'b0, 13'h17FF, 8'h00, 8'h0F, 3'd0};
      vt[9]  = '{1'b0, 13'h1C00, 8'h00, 8'h00, 3'd4};
      vt[10] = '{1'b1, 13'h1C00, 8'h11, 8'h00, 3'd4};
      vt[11] = '{1'b1, 13'h1801, 8'h5A, 8'h00, 3'd0};
      vt[12] = '{1'b0, 13'h1801, 8'h00, 8'h5A, 3'd0};

      preload(13'h0010, 8'h96);
      preload(13'h0100, 8'hC3);
      preload(13'h17FF, 8'h0F);

      repeat (2) @(negedge clk);
      chk("rst_data_out", 32'(data_out), 32'd0);
      chk("rst_oe", 32'(data_oe), 32'd0);
      chk("rst_ready", 32'(ready), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_code", 32'(err_code), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      foreach (vt[i]) begin
         @(negedge clk);
         addr = vt[i].a; data_in = vt[i].d; rd = !vt[i].w; wr = vt[i].w;
         sb.push_back('{!vt[i].w, vt[i].exp_rd});
         @(negedge clk);
         chk("busy_in_wait", 32'(busy), 32'd1);
         wait_ready(lat);
         chk("vec_latency", 32'(lat), 32'd2);
         @(negedge clk);
         chk("ready_single", 32'(ready), 32'd0);
         chk("oe_hold", 32'(data_oe), 32'(!vt[i].w));
         chk("vec_err", 32'(err), 32'(vt[i].exp_code != 3'd0));
         chk("vec_code", 32'(err_code), 32'(vt[i].exp_code));
         rd = 1'b0; wr = 1'b0;
         @(negedge clk);
         chk("oe_drop", 32'(data_oe), 32'd0);
         if (vt[i].exp_code != 3'd0) clear_err();
      end

      // Fetch pattern: rd held high across several cycles gives one access.
      @(negedge clk);
      addr = 13'h0010; rd = 1'b1;
      sb.push_back('{1'b1, 8'h96});
      cnt = 0;
      for (int n = 0; n < 6; n++) begin
         @(negedge clk);
         if (ready) cnt++;
      end
      chk("fetch_ready_count", 32'(cnt), 32'd1);
      chk("fetch_err", 32'(err), 32'd0);
      rd = 1'b0;

      // rd edge while a write is in WAIT is dropped; the write still completes.
      @(negedge clk);
      addr = 13'h1802; data_in = 8'h44; wr = 1'b1;
      sb.push_back('{1'b0, 8'h00});
      @(negedge clk);
      rd = 1'b1;
      wait_ready(lat);
      chk("busy_orig_latency", 32'(lat), 32'd2);
      chk("busy_err", 32'(err), 32'd1);
      chk("busy_code", 32'(err_code), 32'd3);
      rd = 1'b0; wr = 1'b0;
      clear_err();
      do_read(13'h1802, 8'h44);

      // Simultaneous rd/wr edges: no access, code 2.
      @(negedge clk);
      addr = 13'h1800; rd = 1'b1; wr = 1'b1;
      cnt = 0;
      for (int n = 0; n < 5; n++) begin
         @(negedge clk);
         if (ready) cnt++;
      end
      chk("both_no_ready", 32'(cnt), 32'd0);
      chk("both_code", 32'(err_code), 32'd2);
      rd = 1'b0; wr = 1'b0;
      clear_err();

      // Back-to-back: next accept at the edge right after ready.
      @(negedge clk);
      addr = 13'h1800; rd = 1'b1;
      sb.push_back('{1'b1, 8'hA5});
      wait_ready(lat);
      chk("b2b_first_latency", 32'(lat), 32'd3);
      rd = 1'b0; wr = 1'b1; addr = 13'h1804; data_in = 8'h6B;
      sb.push_back('{1'b0, 8'h00});
      wait_ready(lat);
      chk("b2b_second_latency", 32'(lat), 32'd3);
      wr = 1'b0;
      chk("b2b_err", 32'(err), 32'd0);
      do_read(13'h1804, 8'h6B);

      // Reset during WAIT aborts the write; held strobe after release is ignored.
      do_write(13'h1803, 8'h22);
      @(negedge clk);
      addr = 13'h1803; data_in = 8'h99; wr = 1'b1;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_ready", 32'(ready), 32'd0);
      chk("mid_rst_data", 32'(data_out), 32'd0);
      chk("mid_rst_oe", 32'(data_oe), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      cnt = 0;
      for (int n = 0; n < 4; n++) begin
         @(negedge clk);
         if (ready || busy) cnt++;
      end
      chk("held_strobe_ignored", 32'(cnt), 32'd0);
      wr = 1'b0;
      do_read(13'h1803, 8'h22);

`ifdef MEM_RESP_PARITY_EN
      dut.u_array.mem[13'h1801] = dut.u_array.mem[13'h1801] ^ WORD_W'(1);
      do_read(13'h1801, 8'h5B);
      @(negedge clk);
      chk("parity_err", 32'(err), 32'd1);
      chk("parity_code", 32'(err_code), 32'd5);
      clear_err();
`endif

      repeat (3) @(negedge clk);
      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
